// File: rtl/bcd_updown_counter_n.sv
// rtl/bcd_updown_counter_n.sv - multi-decade BCD up/down counter with load, terminal count and overflow
module bcd_updown_counter_n #(
    parameter int DIGITS = 4,
    parameter bit WRAP   = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                dir,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] q,
    output logic                tc,
    output logic                ovf
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0] q_q, q_d;
    logic         ovf_q, ovf_d;
    logic [W-1:0] step_val;
    logic [W-1:0] clamp_val;
    logic         at_limit;
    logic         prop;
    logic [3:0]   dig;
    logic         all_nine;
    logic         all_zero;

    // Ripple carry/borrow decade by decade; a carry surviving the top decade marks the limit
    always_comb begin
        step_val = q_q;
        prop     = 1'b1;
        dig      = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            dig = q_q[4*i +: 4];
            if (prop) begin
                if (dir) begin
                    if (dig >= 4'd9) begin
                        step_val[4*i +: 4] = 4'd0;
                    end else begin
                        step_val[4*i +: 4] = dig + 4'd1;
                        prop               = 1'b0;
                    end
                end else begin
                    if (dig == 4'd0) begin
                        step_val[4*i +: 4] = 4'd9;
                    end else begin
                        step_val[4*i +: 4] = dig - 4'd1;
                        prop               = 1'b0;
                    end
                end
            end
        end
        at_limit = prop;
    end

    // Clamp each loaded nibble into the BCD range so q never holds an illegal digit
    always_comb begin
        clamp_val = load_val;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                clamp_val[4*i +: 4] = 4'd9;
            end
        end
    end

    // Next-state selection: load beats count, saturating builds hold at the limit
    always_comb begin
        q_d   = q_q;
        ovf_d = 1'b0;
        if (load) begin
            q_d = clamp_val;
        end else if (en) begin
            ovf_d = at_limit;
            if (!at_limit || WRAP) begin
                q_d = step_val;
            end
        end
    end

    // State register with synchronous reset taking priority over load and count
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    // Terminal count follows dir combinationally so a direction change shows up immediately
    always_comb begin
        all_nine = 1'b1;
        all_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (q_q[4*i +: 4] != 4'd9) all_nine = 1'b0;
            if (q_q[4*i +: 4] != 4'd0) all_zero = 1'b0;
        end
        tc = dir ? all_nine : all_zero;
    end

    assign q   = q_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// tb/tb_bcd_updown_counter_n.sv - integer-model and directed-vector bench for the BCD up/down counter
module tb_bcd_updown_counter_n;

    logic        clk = 1'b0;
    logic        reset, en, dir, load;
    logic [7:0]  load_val2;
    logic [15:0] load_val4;
    logic [7:0]  q2, qs;
    logic [15:0] q4;
    logic        tc2, tcs, tc4, ovf2, ovfs, ovf4;

    int tests  = 0;
    int failed = 0;
    bit chk_on = 1'b0;

    int m2 = 0, ms = 0, m4 = 0;
    bit o2 = 1'b0, os = 1'b0, o4 = 1'b0;

    always #5 clk = ~clk;

    bcd_updown_counter_n #(.DIGITS(2), .WRAP(1'b1)) dut2 (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load),
        .load_val(load_val2), .q(q2), .tc(tc2), .ovf(ovf2));

    bcd_updown_counter_n #(.DIGITS(2), .WRAP(1'b0)) dut_sat (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load),
        .load_val(load_val2), .q(qs), .tc(tcs), .ovf(ovfs));

    bcd_updown_counter_n #(.DIGITS(4), .WRAP(1'b1)) dut4 (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load),
        .load_val(load_val4), .q(q4), .tc(tc4), .ovf(ovf4));

    function automatic int bcd_to_int(input logic [31:0] v, input int nd);
        int r = 0;
        int d;
        for (int i = nd - 1; i >= 0; i--) begin
            d = int'(v[4*i +: 4]);
            if (d > 9) d = 9;
            r = r * 10 + d;
        end
        return r;
    endfunction

    function automatic logic [31:0] int_to_bcd(input int v, input int nd);
        logic [31:0] r = '0;
        int t = v;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int next_m(input int m, input int maxv, input bit wrap, input int ldv,
                                  input logic rst, input logic ld, input logic e, input logic up);
        if (rst) return 0;
        if (ld) return ldv;
        if (!e) return m;
        if (up) return (m == maxv) ? (wrap ? 0 : m) : m + 1;
        return (m == 0) ? (wrap ? maxv : 0) : m - 1;
    endfunction

    function automatic bit next_ovf(input int m, input int maxv, input logic rst, input logic ld,
                                    input logic e, input logic up);
        return !rst && !ld && e && (up ? (m == maxv) : (m == 0));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integers modulo 10^DIGITS
    always @(posedge clk) begin
        m2 <= next_m(m2, 99, 1'b1, bcd_to_int(32'(load_val2), 2), reset, load, en, dir);
        ms <= next_m(ms, 99, 1'b0, bcd_to_int(32'(load_val2), 2), reset, load, en, dir);
        m4 <= next_m(m4, 9999, 1'b1, bcd_to_int(32'(load_val4), 4), reset, load, en, dir);
        o2 <= next_ovf(m2, 99, reset, load, en, dir);
        os <= next_ovf(ms, 99, reset, load, en, dir);
        o4 <= next_ovf(m4, 9999, reset, load, en, dir);
    end

    // Per-cycle comparison of every instance against the model
    always @(negedge clk) begin
        if (chk_on) begin
            chk("q2",   32'(q2),   int_to_bcd(m2, 2));
            chk("ovf2", 32'(ovf2), 32'(o2));
            chk("tc2",  32'(tc2),  32'(dir ? (m2 == 99) : (m2 == 0)));
            chk("qs",   32'(qs),   int_to_bcd(ms, 2));
            chk("ovfs", 32'(ovfs), 32'(os));
            chk("tcs",  32'(tcs),  32'(dir ? (ms == 99) : (ms == 0)));
            chk("q4",   32'(q4),   int_to_bcd(m4, 4));
            chk("ovf4", 32'(ovf4), 32'(o4));
            chk("tc4",  32'(tc4),  32'(dir ? (m4 == 9999) : (m4 == 0)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; load = 1'b1; dir = 1'b1;
        load_val2 = 8'h57; load_val4 = 16'h1234;

        // reset overrides load and en
        tick();
        chk_on = 1'b1;
        chk("t1_q",   32'(q2),   32'h00);
        chk("t1_ovf", 32'(ovf2), 32'h0);
        chk("t1_tc_up", 32'(tc2), 32'h0);
        dir = 1'b0;
        #1;
        chk("t1_tc_dn", 32'(tc2), 32'h1);

        // up through 99 with wrap
        reset = 1'b0; load = 1'b1; en = 1'b0; load_val2 = 8'h98;
        tick();
        chk("t2_load", 32'(q2), 32'h98);
        load = 1'b0; dir = 1'b1; en = 1'b1;
        tick();
        chk("t2_q99",  32'(q2), 32'h99);
        chk("t2_tc",   32'(tc2), 32'h1);
        tick();
        chk("t2_q00",  32'(q2), 32'h00);
        chk("t2_ovf1", 32'(ovf2), 32'h1);
        chk("t2_sat",  32'(qs), 32'h99);
        tick();
        chk("t2_q01",  32'(q2), 32'h01);
        chk("t2_ovf0", 32'(ovf2), 32'h0);

        // borrow across a decade
        load = 1'b1; en = 1'b0; load_val2 = 8'h10;
        tick();
        load = 1'b0; dir = 1'b0; en = 1'b1;
        tick();
        chk("t3_q09", 32'(q2), 32'h09);
        tick();
        chk("t3_q08", 32'(q2), 32'h08);
        chk("t3_ovf", 32'(ovf2), 32'h0);

        // down at zero: wrap vs saturate
        reset = 1'b1; en = 1'b0;
        tick();
        reset = 1'b0; en = 1'b1; dir = 1'b0;
        tick();
        chk("t4_q99",    32'(q2),   32'h99);
        chk("t4_ovf",    32'(ovf2), 32'h1);
        chk("t4_sat_q",  32'(qs),   32'h00);
        chk("t4_sat_ov", 32'(ovfs), 32'h1);
        tick();
        chk("t4_q98",    32'(q2),   32'h98);
        chk("t4_ovf0",   32'(ovf2), 32'h0);
        chk("t4_sat_ov2", 32'(ovfs), 32'h1);
        en = 1'b0;
        tick();
        chk("t4_sat_ov3", 32'(ovfs), 32'h0);

        // clamped load beats en
        load = 1'b1; en = 1'b1; dir = 1'b1; load_val2 = 8'hAC;
        tick();
        chk("t5_q",   32'(q2),   32'h99);
        chk("t5_ovf", 32'(ovf2), 32'h0);

        // four-decade carry and wrap
        load = 1'b1; en = 1'b0; load_val4 = 16'h0999;
        tick();
        load = 1'b0; en = 1'b1; dir = 1'b1;
        tick();
        chk("t6_q1000", 32'(q4), 32'h1000);
        load = 1'b1; en = 1'b0; load_val4 = 16'h9999;
        tick();
        load = 1'b0; en = 1'b1;
        tick();
        chk("t6_q0000", 32'(q4), 32'h0000);
        chk("t6_ovf",   32'(ovf4), 32'h1);

        // randomized traffic against the model
        for (int n = 0; n < 10000; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            load  = ($urandom_range(0, 15) == 0);
            en    = ($urandom_range(0, 3) != 0);
            dir   = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: begin load_val2 = 8'h99; load_val4 = 16'h9999; end
                1: begin load_val2 = 8'h00; load_val4 = 16'h0000; end
                default: begin load_val2 = 8'($urandom); load_val4 = 16'($urandom); end
            endcase
            tick();
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
